// File: rtl/tcm_axis_reader_m.sv
// AXI-Stream master that reads a block of TCM words and streams them out.
// Single-cycle-latency TCM reads feed a 2-entry FIFO that drives the stream.
module tcm_axis_reader_m #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_TCM_ADDR_WIDTH     = 10
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic [31:0]                       USR_tcm_control,
  output logic                              busy,
  output logic                              done,
  output logic                              tcm_rd_en,
  output logic [C_TCM_ADDR_WIDTH-1:0]       tcm_rd_addr,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   tcm_rd_data,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int AW = C_TCM_ADDR_WIDTH;
  localparam int CW = AW + 1;
  localparam logic [31:0] DEPTH = 32'd1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ZERO} state_e;

  state_e         state_q, state_d;
  logic           start_prev_q;
  logic [CW-1:0]  nlat_q, nlat_d;
  logic [CW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  sent_q, sent_d;
  logic           inflight_q;
  logic [DW-1:0]  fifo_mem_q [2];
  logic           fifo_wr_q, fifo_rd_q;
  logic [1:0]     fifo_cnt_q;

  logic           start_edge, abort_act, tvalid, pop, push, last_beat;
  logic           rd_en_c, done_c;
  logic [31:0]    n_ext;
  logic [CW-1:0]  n_clip;
  logic           ctrl_unused;

  assign ctrl_unused = ^USR_tcm_control[15:2];

  assign start_edge = USR_tcm_control[0] & ~start_prev_q;
  assign abort_act  = USR_tcm_control[1] & ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign tvalid     = (fifo_cnt_q != 2'd0);
  assign pop        = tvalid & M_AXIS_TREADY;
  // A read landing in the abort cycle is dropped together with the FIFO contents.
  assign push       = inflight_q & ~abort_act;
  assign last_beat  = tvalid & (sent_q == nlat_q - CW'(1));

  assign n_ext  = {16'd0, USR_tcm_control[31:16]};
  assign n_clip = (n_ext > DEPTH) ? DEPTH[CW-1:0] : n_ext[CW-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d  = state_q;
    nlat_d   = nlat_q;
    rd_ptr_d = rd_ptr_q;
    sent_d   = pop ? sent_q + CW'(1) : sent_q;
    rd_en_c  = 1'b0;
    done_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          nlat_d   = n_clip;
          rd_ptr_d = '0;
          sent_d   = '0;
          state_d  = (n_clip == '0) ? S_ZERO : S_RUN;
        end
      end
      S_ZERO: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (abort_act) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end else if ((3'(fifo_cnt_q) + 3'(inflight_q)) < 3'd2) begin
          rd_en_c  = 1'b1;
          rd_ptr_d = rd_ptr_q + CW'(1);
          if (rd_ptr_d == nlat_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort_act || (pop && last_beat)) begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state_q      <= S_IDLE;
      // Tracks the live level in reset so a start held high through reset is not an edge.
      start_prev_q <= USR_tcm_control[0];
      nlat_q       <= '0;
      rd_ptr_q     <= '0;
      sent_q       <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= USR_tcm_control[0];
      nlat_q       <= nlat_d;
      rd_ptr_q     <= rd_ptr_d;
      sent_q       <= sent_d;
      inflight_q   <= rd_en_c;
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      // NOTE: the two storage words are reset too, so TDATA reads zero out of reset.
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else if (abort_act) begin
      fifo_wr_q     <= 1'b0;
      fifo_rd_q     <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem_q[fifo_wr_q] <= tcm_rd_data;
        fifo_wr_q             <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_c;
  assign tcm_rd_en     = rd_en_c;
  assign tcm_rd_addr   = rd_ptr_q[AW-1:0];
  assign M_AXIS_TVALID = tvalid;
  assign M_AXIS_TDATA  = fifo_mem_q[fifo_rd_q];
  assign M_AXIS_TSTRB  = {(DW/8){tvalid}};
  assign M_AXIS_TLAST  = last_beat;

endmodule

// File: tb/tb_tcm_axis_reader_m.sv
// Scoreboard bench for tcm_axis_reader_m with a 16-word TCM model.
// Stimulus queues expected beats; a negedge monitor checks every accepted beat.
module tb_tcm_axis_reader_m;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   ctrl;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          tvalid, tlast, tready;
  logic [DW-1:0] tdata;
  logic [3:0]    tstrb;

  always #5 clk = ~clk;

  tcm_axis_reader_m #(.C_M_AXIS_TDATA_WIDTH(DW), .C_TCM_ADDR_WIDTH(AW)) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rstn),
    .USR_tcm_control(ctrl),
    .busy           (busy),
    .done           (done),
    .tcm_rd_en      (rd_en),
    .tcm_rd_addr    (rd_addr),
    .tcm_rd_data    (rd_data),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TSTRB   (tstrb),
    .M_AXIS_TLAST   (tlast),
    .M_AXIS_TREADY  (tready)
  );

  logic [DW-1:0] tcm [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) tcm[i] = 32'h100 + i;
  always @(posedge clk) if (rd_en) rd_data <= tcm[rd_addr];

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  beat_t exp_q[$];

  int n_tests = 0, n_fail = 0;
  int acc_cnt = 0, done_cnt = 0, exp_addr = 0, outstanding = 0;
  bit toggle_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tready = toggle_mode ? ~tready : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t b;
    if (rstn) begin
      if (done) done_cnt++;
      if (rd_en) begin
        check("rd_credit", 32'(outstanding < 2), 32'd1);
        check("rd_addr", 32'(rd_addr), 32'(exp_addr));
        exp_addr++;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(tvalid), 32'd1);
        check("stall_data", tdata, prev_data);
        check("stall_last", 32'(tlast), 32'(prev_last));
      end
      if (tvalid) check("tstrb", 32'(tstrb), 32'hf);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h with no beat expected", tdata);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", tdata, b.data);
          check("beat_last", 32'(tlast), 32'(b.last));
          if (b.last) check("done_with_last", 32'(done), 32'd1);
        end
        acc_cnt++;
      end
      outstanding += int'(rd_en) - int'(tvalid && tready);
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end else begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end
  end

  // Caller is at posedge+#1; returns at posedge+#1 after the start cycle.
  task automatic start(input int n);
    int nl;
    nl = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < nl; i++) exp_q.push_back('{data: 32'h100 + i, last: (i == nl - 1)});
    exp_addr = 0;
    ctrl = {n[15:0], 16'h0001};
    @(posedge clk); #1;
    ctrl[0] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_complete"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_accepted(input string name, input int target);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (acc_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    check({name, "_reached"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int d0, a0;
    rstn = 1'b0;
    ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tlast", 32'(tlast), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 1) N=4, TREADY high
    d0 = done_cnt; a0 = acc_cnt;
    start(4);
    wait_idle("t1");
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_beats", 32'(acc_cnt - a0), 32'd4);
    check("t1_busy", 32'(busy), 32'd0);

    // 2) N=8, TREADY toggling
    toggle_mode = 1'b1;
    d0 = done_cnt; a0 = acc_cnt;
    start(8);
    wait_idle("t2");
    toggle_mode = 1'b0;
    check("t2_done", 32'(done_cnt - d0), 32'd1);
    check("t2_beats", 32'(acc_cnt - a0), 32'd8);

    // 3) N=0
    @(posedge clk); #1;
    d0 = done_cnt; a0 = acc_cnt;
    start(0);
    wait_idle("t3");
    repeat (3) @(posedge clk);
    #1;
    check("t3_done", 32'(done_cnt - d0), 32'd1);
    check("t3_beats", 32'(acc_cnt - a0), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);

    // 4) N=40 clipped to DEPTH=16
    d0 = done_cnt; a0 = acc_cnt;
    start(40);
    wait_idle("t4");
    check("t4_done", 32'(done_cnt - d0), 32'd1);
    check("t4_beats", 32'(acc_cnt - a0), 32'd16);
    check("t4_reads", 32'(exp_addr), 32'd16);

    // 5) N=16, abort after 5 accepted beats, then N=2
    d0 = done_cnt; a0 = acc_cnt;
    start(16);
    wait_accepted("t5", a0 + 5);
    ctrl[1] = 1'b1;
    @(posedge clk); #1;
    ctrl[1] = 1'b0;
    exp_q.delete();
    outstanding = 0;
    check("t5_tvalid_low", 32'(tvalid), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_done", 32'(done_cnt - d0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_tvalid_stays_low", 32'(tvalid), 32'd0);
    d0 = done_cnt; a0 = acc_cnt;
    start(2);
    wait_idle("t5b");
    check("t5b_done", 32'(done_cnt - d0), 32'd1);
    check("t5b_beats", 32'(acc_cnt - a0), 32'd2);

    // 6) reset during beat 3 of 10, start held high through reset
    a0 = acc_cnt;
    start(10);
    wait_accepted("t6", a0 + 2);
    rstn = 1'b0;
    ctrl = {16'd3, 16'h0001};
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    d0 = done_cnt; a0 = acc_cnt;
    check("t6_tvalid_low", 32'(tvalid), 32'd0);
    check("t6_busy_low", 32'(busy), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("t6_no_retrigger", 32'(busy), 32'd0);
    end
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_no_beats", 32'(acc_cnt - a0), 32'd0);
    ctrl[0] = 1'b0;
    @(posedge clk); #1;
    start(3);
    wait_idle("t6b");
    check("t6b_done", 32'(done_cnt - d0), 32'd1);
    check("t6b_beats", 32'(acc_cnt - a0), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
